// File: rtl/bias_stream_loader_if.sv
// Lane-parallel input/output stream bundle for the bias loader.
// Handshakes are valid/ready; payload is an unpacked array of lanes.
interface bias_stream_loader_if #(
    parameter int LANES = 1,
    parameter int W     = 16
) ();
    logic [W-1:0] data_in [LANES];
    logic         data_in_valid;
    logic         data_in_ready;
    logic [W-1:0] data_out [LANES];
    logic         data_out_valid;
    logic         data_out_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_valid
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_valid
    );
endinterface

// File: rtl/bias_stream_loader.sv
// Captures one bias tensor into RAM, then replays it beat by beat forever.
// First beat 2 cycles after STREAM entry; 2-entry skid absorbs output stalls, input ready is state-only.
module bias_stream_loader #(
    parameter int BIAS_TENSOR_SIZE_DIM_0 = 32,
    parameter int BIAS_TENSOR_SIZE_DIM_1 = 1,
    parameter int BIAS_PRECISION_0       = 16,
    parameter int BIAS_PRECISION_1       = 3,
    parameter int BIAS_PARALLELISM_DIM_0 = 1,
    parameter int BIAS_PARALLELISM_DIM_1 = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    bias_stream_loader_if.slave  bus,
    input  logic                 load_start,
    output logic                 loaded,
    output logic                 pass_done
);
    localparam int W      = BIAS_PRECISION_0;
    localparam int LANES  = BIAS_PARALLELISM_DIM_0 * BIAS_PARALLELISM_DIM_1;
    localparam int DEPTH  = (BIAS_TENSOR_SIZE_DIM_0 * BIAS_TENSOR_SIZE_DIM_1) / LANES;
    localparam int BW     = LANES * W;
    localparam int PW     = $clog2(DEPTH + 1);
    localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int RAM_N  = 1 << AW;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    if (BIAS_PRECISION_1 > BIAS_PRECISION_0) begin : g_bad_frac
        $error("fractional bits exceed element width");
    end
    if (DEPTH * LANES != BIAS_TENSOR_SIZE_DIM_0 * BIAS_TENSOR_SIZE_DIM_1) begin : g_bad_depth
        $error("tensor size is not a whole number of beats");
    end

    typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_t;
    state_t state_q, state_d;

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [BW-1:0] ram [0:RAM_N-1];
    logic [BW-1:0] wr_dat, rd_dat;
    logic          rd_vld_q, rd_last_q;

    logic [BW-1:0] buf_dat  [2];
    logic          buf_last [2];
    logic          buf_rd_idx, buf_wr_idx;
    logic [1:0]    buf_cnt;

    logic       wr_en, last_wr, stream_run, rd_en, out_fire, push;
    logic [1:0] occ, occ_after;

    // A load_start in LOAD restarts the capture, so it wins over a coincident beat.
    assign wr_en      = (state_q == LOAD) && bus.data_in_valid && !load_start;
    assign last_wr    = wr_en && (wr_ptr_q == LAST);
    assign stream_run = (state_q == STREAM) && !load_start;

    assign bus.data_in_ready  = (state_q == LOAD);
    assign bus.data_out_valid = (buf_cnt != 2'd0);
    assign out_fire           = bus.data_out_valid && bus.data_out_ready;
    assign pass_done          = out_fire && buf_last[buf_rd_idx];

    // Beats already buffered plus one in flight must never exceed the two skid slots.
    assign occ       = buf_cnt + {1'b0, rd_vld_q};
    assign occ_after = occ - {1'b0, out_fire};
    assign rd_en     = stream_run && (occ_after < 2'd2);
    assign push      = rd_vld_q && stream_run;

    always_comb begin
        wr_dat = '0;
        for (int j = 0; j < LANES; j++) begin
            wr_dat[j*W +: W] = bus.data_in[j];
        end
    end

    always_comb begin
        for (int j = 0; j < LANES; j++) begin
            bus.data_out[j] = buf_dat[buf_rd_idx][j*W +: W];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (load_start) state_d = LOAD;
            LOAD:    if (last_wr)    state_d = STREAM;
            STREAM:  if (load_start) state_d = LOAD;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_vld_q  <= 1'b0;
            rd_last_q <= 1'b0;
            loaded    <= 1'b0;
        end else begin
            if (load_start) begin
                wr_ptr_q <= '0;
            end else if (wr_en) begin
                wr_ptr_q <= last_wr ? '0 : wr_ptr_q + PW'(1);
            end

            if (!stream_run) begin
                rd_ptr_q <= '0;
            end else if (rd_en) begin
                rd_ptr_q <= (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PW'(1);
            end

            rd_vld_q  <= rd_en;
            rd_last_q <= rd_en && (rd_ptr_q == LAST);

            if (load_start) begin
                loaded <= 1'b0;
            end else if (last_wr) begin
                loaded <= 1'b1;
            end
        end
    end

    // Tensor storage is intentionally left unreset; only a fresh load defines it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            ram[wr_ptr_q[AW-1:0]] <= wr_dat;
        end
        if (rd_en) begin
            rd_dat <= ram[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_dat[0]  <= '0;
            buf_dat[1]  <= '0;
            buf_last[0] <= 1'b0;
            buf_last[1] <= 1'b0;
            buf_rd_idx  <= 1'b0;
            buf_wr_idx  <= 1'b0;
            buf_cnt     <= 2'd0;
        end else if (!stream_run) begin
            buf_rd_idx <= 1'b0;
            buf_wr_idx <= 1'b0;
            buf_cnt    <= 2'd0;
        end else begin
            if (push) begin
                buf_dat[buf_wr_idx]  <= rd_dat;
                buf_last[buf_wr_idx] <= rd_last_q;
                buf_wr_idx           <= ~buf_wr_idx;
            end
            if (out_fire) begin
                buf_rd_idx <= ~buf_rd_idx;
            end
            buf_cnt <= buf_cnt + {1'b0, push} - {1'b0, out_fire};
        end
    end
endmodule

// File: doc/bias_stream_loader.md
BIAS_STREAM_LOADER -- requirements
Module: bias_stream_loader

Interface
REQ-001 SHALL have parameter BIAS_TENSOR_SIZE_DIM_0, default 32: tensor elements along dim 0.
REQ-002 SHALL have parameter BIAS_TENSOR_SIZE_DIM_1, default 1: tensor elements along dim 1.
REQ-003 SHALL have parameter BIAS_PRECISION_0, default 16: element total width W.
REQ-004 SHALL have parameter BIAS_PRECISION_1, default 3: fractional bits; metadata only, no arithmetic use.
REQ-005 SHALL have parameter BIAS_PARALLELISM_DIM_0, default 1: elements per beat P.
REQ-006 SHALL have parameter BIAS_PARALLELISM_DIM_1, default 1: beat rows (product with DIM_0 gives lanes).
REQ-007 SHALL derive DEPTH = DIM_0*DIM_1 sizes / (PAR_DIM_0*PAR_DIM_1), the beats per tensor; default 32.
REQ-008 SHALL have ports: clk in 1 (single clock, all logic on posedge); rst in 1 (asynchronous, active-high).
REQ-009 SHALL have ports: data_in in P x W (unpacked array, lane j = element j); data_in_valid in 1; data_in_ready out 1.
REQ-010 SHALL have ports: data_out out P x W; data_out_valid out 1; data_out_ready in 1.
REQ-011 SHALL have ports: load_start in 1 (single-cycle request to capture a new tensor); loaded out 1 (tensor resident); pass_done out 1 (pulse on last beat of each output pass).

Function
REQ-012 SHALL use a DEPTH-entry P*W-bit RAM with a one-cycle synchronous read port.
REQ-013 SHALL implement an FSM with three states: IDLE, LOAD, STREAM.
REQ-014 In IDLE: data_in_ready=0 and data_out_valid=0; load_start moves the FSM to LOAD on the next edge.
REQ-015 In LOAD: data_in_ready=1; each data_in_valid&&data_in_ready cycle writes the packed lanes to ram[wr_ptr] and increments wr_ptr.
REQ-016 The handshake at wr_ptr==DEPTH-1 SHALL write the entry, clear wr_ptr, set loaded=1 and enter STREAM on the same edge.
REQ-017 load_start while in LOAD SHALL restart the load: wr_ptr=0. A coincident data_in handshake is discarded.
REQ-018 load_start while in STREAM SHALL abort streaming: flush the output buffer, set data_out_valid=0 and loaded=0 next cycle, enter LOAD.
REQ-019 In STREAM: entries SHALL be emitted in index order 0..DEPTH-1 and wrap to 0 indefinitely.
REQ-020 Output SHALL be buffered through a 2-entry skid buffer so that, with data_out_ready held high, one beat is accepted every cycle with no bubbles.
REQ-021 The first data_out_valid SHALL assert exactly 2 cycles after the edge that entered STREAM.
REQ-022 While data_out_valid && !data_out_ready, data_out SHALL hold stable and valid SHALL not drop.
REQ-023 RAM reads SHALL be issued only when a buffer slot is free or frees in that cycle; no beat is lost or duplicated.
REQ-024 pass_done SHALL pulse high for exactly the cycle in which the beat with index DEPTH-1 handshakes at the output.
REQ-025 Pointers SHALL be $clog2(DEPTH+1) bits wide; wrap compares against DEPTH-1 exactly, for any DEPTH including 1.
REQ-026 data_in_ready SHALL depend only on state, not combinationally on data_in_valid.

Reset
REQ-027 rst SHALL asynchronously force: state=IDLE, wr_ptr=0, rd_ptr=0, skid buffer empty, data_in_ready=0, data_out_valid=0, data_out=0, loaded=0, pass_done=0.
REQ-028 RAM contents SHALL not be reset; reset mid-LOAD or mid-STREAM SHALL abandon the operation, and a fresh load_start is required.

Verification
REQ-029 Reset, pulse load_start, drive 32 beats 0x0000..0x001F with valid high -> loaded=1 after the 32nd handshake; data_out_valid rises 2 cycles later with data_out=0x0000.
REQ-030 After that load, hold data_out_ready=1 for 70 cycles -> sequence 0x00..0x1F, 0x00..0x1F, 0x00..0x05 with no gaps; pass_done high on both 0x1F beats.
REQ-031 Random data_out_ready (50%) and random data_in_valid gaps -> output order is preserved, with no drop or duplicate over 3 passes, and data_out is stable while stalled.
REQ-032 Load 10 beats, pulse load_start together with beat 11, then load 0x0100..0x011F -> output streams 0x0100..0x011F only.
REQ-033 In STREAM after beat 0x07 is accepted, pulse load_start -> valid=0 and loaded=0 next cycle; the new load replaces contents and streaming restarts at index 0.
REQ-034 Assert rst asynchronously mid-LOAD (between edges) -> all outputs reach their REQ-027 values immediately; data_in_ready=0 until load_start.
